// File: rtl/ber_sweep_ctrl.sv
// ber_sweep_ctrl: steps MAIN_MODE from FIRST_MODE to LAST_MODE; each step clears, settles, dwells, captures counters.
// Latency: the result is valid CLR_CYC + SETTLE_CYC + max(DWELL_CYC,1) + 1 cycles after CLR rises for that mode.
// Backpressure: REPORT holds RES_* and MAIN_MODE until RES_READY; ABORT or RSTX abandon the sweep at any point.
// Ports: CLK/RSTX clock and async active-low reset; START/ABORT with FIRST_MODE..DWELL_CYC sweep control;
//        MAIN_MODE/SUB_MODE/CLR to the stimulus block, RECV_CNT/ERR_CNT back from it;
//        RES_VALID/RES_READY/RES_MODE/RES_RECV/RES_ERR result handshake; BUSY/DONE status.
module ber_sweep_ctrl #(
    parameter int unsigned CLR_CYC   = 4,
    parameter logic [7:0]  IDLE_MODE = 8'd0
) (
    input  logic        CLK,
    input  logic        RSTX,
    input  logic        START,
    input  logic        ABORT,
    input  logic [7:0]  FIRST_MODE,
    input  logic [7:0]  LAST_MODE,
    input  logic [7:0]  SUB_MODE_IN,
    input  logic [15:0] SETTLE_CYC,
    input  logic [31:0] DWELL_CYC,
    output logic [7:0]  MAIN_MODE,
    output logic [7:0]  SUB_MODE,
    output logic        CLR,
    input  logic [57:0] RECV_CNT,
    input  logic [63:0] ERR_CNT,
    output logic        RES_VALID,
    input  logic        RES_READY,
    output logic [7:0]  RES_MODE,
    output logic [57:0] RES_RECV,
    output logic [63:0] RES_ERR,
    output logic        BUSY,
    output logic        DONE
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SETTLE,
        S_DWELL,
        S_CAPTURE,
        S_REPORT
    } state_t;

    localparam logic [31:0] CLR_LAST = 32'(CLR_CYC - 1);

    state_t      state_q,     state_d;
    logic [31:0] cnt_q,       cnt_d;
    logic [7:0]  last_q,      last_d;
    logic [15:0] settle_q,    settle_d;
    logic [31:0] dwell_q,     dwell_d;
    logic [7:0]  main_mode_q, main_mode_d;
    logic [7:0]  sub_mode_q,  sub_mode_d;
    logic        clr_q,       clr_d;
    logic        res_valid_q, res_valid_d;
    logic [7:0]  res_mode_q,  res_mode_d;
    logic [57:0] res_recv_q,  res_recv_d;
    logic [63:0] res_err_q,   res_err_d;
    logic        busy_q,      busy_d;
    logic        done_q,      done_d;

    logic [31:0] settle_last;
    logic [31:0] dwell_last;

    // Terminal counts; a zero dwell is run as a single cycle. Counters are
    // compared with >= so a counter can never run past its programmed length.
    assign settle_last = {16'd0, settle_q} - 32'd1;
    assign dwell_last  = (dwell_q == 32'd0) ? 32'd0 : dwell_q - 32'd1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        settle_d    = settle_q;
        dwell_d     = dwell_q;
        main_mode_d = main_mode_q;
        sub_mode_d  = sub_mode_q;
        clr_d       = clr_q;
        res_valid_d = res_valid_q;
        res_mode_d  = res_mode_q;
        res_recv_d  = res_recv_q;
        res_err_d   = res_err_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (START && !ABORT) begin
                    if (FIRST_MODE <= LAST_MODE) begin
                        last_d      = LAST_MODE;
                        settle_d    = SETTLE_CYC;
                        dwell_d     = DWELL_CYC;
                        main_mode_d = FIRST_MODE;
                        sub_mode_d  = SUB_MODE_IN;
                        clr_d       = 1'b1;
                        cnt_d       = 32'd0;
                        state_d     = S_CLEAR;
                    end else begin
                        // Empty range: report completion without any result.
                        done_d = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                if (cnt_q >= CLR_LAST) begin
                    clr_d   = 1'b0;
                    cnt_d   = 32'd0;
                    state_d = (settle_q != 16'd0) ? S_SETTLE : S_DWELL;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_SETTLE: begin
                if (cnt_q >= settle_last) begin
                    cnt_d   = 32'd0;
                    state_d = S_DWELL;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_DWELL: begin
                if (cnt_q >= dwell_last) begin
                    cnt_d   = 32'd0;
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_CAPTURE: begin
                res_recv_d  = RECV_CNT;
                res_err_d   = ERR_CNT;
                res_mode_d  = main_mode_q;
                res_valid_d = 1'b1;
                state_d     = S_REPORT;
            end
            S_REPORT: begin
                if (RES_READY) begin
                    res_valid_d = 1'b0;
                    // Compare before incrementing so mode 255 never wraps.
                    if (main_mode_q == last_q) begin
                        main_mode_d = IDLE_MODE;
                        done_d      = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        main_mode_d = main_mode_q + 8'd1;
                        clr_d       = 1'b1;
                        cnt_d       = 32'd0;
                        state_d     = S_CLEAR;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides everything above, including a REPORT handshake.
        if (ABORT && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            clr_d       = 1'b0;
            res_valid_d = 1'b0;
            main_mode_d = IDLE_MODE;
            done_d      = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            state_q     <= S_IDLE;
            cnt_q       <= 32'd0;
            last_q      <= 8'd0;
            settle_q    <= 16'd0;
            dwell_q     <= 32'd0;
            main_mode_q <= IDLE_MODE;
            sub_mode_q  <= 8'd0;
            clr_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_mode_q  <= 8'd0;
            res_recv_q  <= 58'd0;
            res_err_q   <= 64'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            settle_q    <= settle_d;
            dwell_q     <= dwell_d;
            main_mode_q <= main_mode_d;
            sub_mode_q  <= sub_mode_d;
            clr_q       <= clr_d;
            res_valid_q <= res_valid_d;
            res_mode_q  <= res_mode_d;
            res_recv_q  <= res_recv_d;
            res_err_q   <= res_err_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign MAIN_MODE = main_mode_q;
    assign SUB_MODE  = sub_mode_q;
    assign CLR       = clr_q;
    assign RES_VALID = res_valid_q;
    assign RES_MODE  = res_mode_q;
    assign RES_RECV  = res_recv_q;
    assign RES_ERR   = res_err_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;

endmodule

// File: tb/tb_ber_sweep_ctrl.sv
// tb_ber_sweep_ctrl: drives directed and randomized sweeps into ber_sweep_ctrl and compares every output each cycle
// against a position-in-step reference model (step = clear + settle + dwell + capture, then report until accepted).
// Counter inputs are randomized every cycle so captured values are checked against what was on the bus.
module tb_ber_sweep_ctrl;

    localparam int CLR_CYC = 4;

    logic        CLK = 1'b0;
    logic        RSTX = 1'b1;
    logic        START = 1'b0;
    logic        ABORT = 1'b0;
    logic [7:0]  FIRST_MODE = 8'd0;
    logic [7:0]  LAST_MODE = 8'd0;
    logic [7:0]  SUB_MODE_IN = 8'd0;
    logic [15:0] SETTLE_CYC = 16'd0;
    logic [31:0] DWELL_CYC = 32'd0;
    logic [7:0]  MAIN_MODE;
    logic [7:0]  SUB_MODE;
    logic        CLR;
    logic [57:0] RECV_CNT = 58'd0;
    logic [63:0] ERR_CNT = 64'd0;
    logic        RES_VALID;
    logic        RES_READY = 1'b0;
    logic [7:0]  RES_MODE;
    logic [57:0] RES_RECV;
    logic [63:0] RES_ERR;
    logic        BUSY;
    logic        DONE;

    always #5 CLK = ~CLK;

    ber_sweep_ctrl #(
        .CLR_CYC   (CLR_CYC),
        .IDLE_MODE (8'd0)
    ) dut (
        .CLK         (CLK),
        .RSTX        (RSTX),
        .START       (START),
        .ABORT       (ABORT),
        .FIRST_MODE  (FIRST_MODE),
        .LAST_MODE   (LAST_MODE),
        .SUB_MODE_IN (SUB_MODE_IN),
        .SETTLE_CYC  (SETTLE_CYC),
        .DWELL_CYC   (DWELL_CYC),
        .MAIN_MODE   (MAIN_MODE),
        .SUB_MODE    (SUB_MODE),
        .CLR         (CLR),
        .RECV_CNT    (RECV_CNT),
        .ERR_CNT     (ERR_CNT),
        .RES_VALID   (RES_VALID),
        .RES_READY   (RES_READY),
        .RES_MODE    (RES_MODE),
        .RES_RECV    (RES_RECV),
        .RES_ERR     (RES_ERR),
        .BUSY        (BUSY),
        .DONE        (DONE)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: a sweep is a sequence of steps; within a step the
    // position counts cycles from the first CLR cycle. CLR covers the first
    // CLR_CYC positions, the result is valid from position m_len onward.
    bit          m_active;
    logic [7:0]  m_mode;
    logic [7:0]  m_last;
    logic [7:0]  m_sub;
    int          m_pos;
    int          m_len;
    bit          m_done;
    logic [7:0]  m_rmode;
    logic [57:0] m_recv;
    logic [63:0] m_err;

    int done_seen = 0;
    int res_seen  = 0;
    bit prev_valid = 1'b0;

    task automatic model_reset();
        m_active = 1'b0;
        m_mode   = 8'd0;
        m_last   = 8'd0;
        m_sub    = 8'd0;
        m_pos    = 0;
        m_len    = 0;
        m_done   = 1'b0;
        m_rmode  = 8'd0;
        m_recv   = 58'd0;
        m_err    = 64'd0;
    endtask

    task automatic model_edge();
        m_done = 1'b0;
        if (!m_active) begin
            if (START && !ABORT) begin
                if (FIRST_MODE <= LAST_MODE) begin
                    m_active = 1'b1;
                    m_mode   = FIRST_MODE;
                    m_last   = LAST_MODE;
                    m_sub    = SUB_MODE_IN;
                    m_len    = CLR_CYC + int'(SETTLE_CYC) + ((DWELL_CYC == 0) ? 1 : int'(DWELL_CYC)) + 1;
                    m_pos    = 0;
                end else begin
                    m_done = 1'b1;
                end
            end
        end else if (ABORT) begin
            m_active = 1'b0;
        end else if (m_pos >= m_len) begin
            if (RES_READY) begin
                if (m_mode == m_last) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end else begin
                    m_mode = m_mode + 8'd1;
                    m_pos  = 0;
                end
            end
        end else begin
            if (m_pos == m_len - 1) begin
                m_rmode = m_mode;
                m_recv  = RECV_CNT;
                m_err   = ERR_CNT;
            end
            m_pos++;
        end
    endtask

    task automatic check_outputs();
        chk("busy",      64'(BUSY),      64'(m_active));
        chk("clr",       64'(CLR),       64'(m_active && (m_pos < CLR_CYC)));
        chk("main_mode", 64'(MAIN_MODE), 64'(m_active ? m_mode : 8'd0));
        chk("sub_mode",  64'(SUB_MODE),  64'(m_sub));
        chk("res_valid", 64'(RES_VALID), 64'(m_active && (m_pos >= m_len)));
        chk("done",      64'(DONE),      64'(m_done));
        chk("res_mode",  64'(RES_MODE),  64'(m_rmode));
        chk("res_recv",  64'(RES_RECV),  64'(m_recv));
        chk("res_err",   64'(RES_ERR),   m_err);
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        check_outputs();
        if (DONE) done_seen++;
        if (RES_VALID && !prev_valid) res_seen++;
        prev_valid = RES_VALID;
        RECV_CNT = 58'({$urandom(), $urandom()});
        ERR_CNT  = {$urandom(), $urandom()};
    endtask

    // rdy_mode: 0 = always ready, 1 = random ready, 2 = ready held low for 20 report cycles.
    task automatic run_sweep(input string tag, input logic [7:0] f, input logic [7:0] l,
                             input logic [15:0] s, input logic [31:0] d, input int rdy_mode,
                             input int abort_mode, input int abort_pos, input int exp_res, input int exp_done);
        int n;
        int rep;
        n = 0;
        rep = 0;
        done_seen = 0;
        res_seen = 0;
        FIRST_MODE  = f;
        LAST_MODE   = l;
        SUB_MODE_IN = 8'($urandom_range(1, 255));
        SETTLE_CYC  = s;
        DWELL_CYC   = d;
        START = 1'b1;
        step();
        START = 1'b0;
        // Scramble the configuration: the sweep must run on the latched copy.
        FIRST_MODE  = 8'($urandom());
        LAST_MODE   = 8'($urandom());
        SUB_MODE_IN = 8'($urandom());
        SETTLE_CYC  = 16'($urandom_range(0, 7));
        DWELL_CYC   = 32'($urandom_range(0, 7));
        while (m_active && n < 5000) begin
            if (m_pos >= m_len) rep++;
            else rep = 0;
            case (rdy_mode)
                0:       RES_READY = 1'b1;
                1:       RES_READY = ($urandom_range(0, 2) != 0);
                default: RES_READY = (rep > 20);
            endcase
            ABORT = (int'(m_mode) == abort_mode) && (m_pos == abort_pos);
            step();
            n++;
        end
        ABORT = 1'b0;
        RES_READY = 1'b0;
        if (n >= 5000) chk({tag, "_timeout"}, 64'(n), 64'd0);
        step();
        step();
        chk({tag, "_results"}, 64'(res_seen), 64'(exp_res));
        chk({tag, "_done"},    64'(done_seen), 64'(exp_done));
    endtask

    initial begin
        logic [7:0] rf;
        logic [7:0] rl;
        model_reset();
        #2 RSTX = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check_outputs();
        @(negedge CLK);
        RSTX = 1'b1;
        repeat (2) step();

        run_sweep("normal",  8'd9,   8'd11,  16'd2, 32'd10, 0, -1, 0, 3, 1);
        run_sweep("bp",      8'd3,   8'd5,   16'd1, 32'd4,  2, -1, 0, 3, 1);
        run_sweep("min",     8'd31,  8'd31,  16'd0, 32'd0,  0, -1, 0, 1, 1);
        run_sweep("rev",     8'd12,  8'd10,  16'd2, 32'd10, 0, -1, 0, 0, 1);
        run_sweep("top",     8'd255, 8'd255, 16'd1, 32'd2,  1, -1, 0, 1, 1);
        run_sweep("abort",   8'd9,   8'd11,  16'd2, 32'd10, 0, 10, CLR_CYC + 2 + 3, 1, 0);

        // START and ABORT together in IDLE: nothing starts.
        FIRST_MODE = 8'd1;
        LAST_MODE  = 8'd2;
        START = 1'b1;
        ABORT = 1'b1;
        step();
        START = 1'b0;
        ABORT = 1'b0;
        repeat (3) step();

        // Asynchronous reset in the middle of the clear phase.
        FIRST_MODE  = 8'd20;
        LAST_MODE   = 8'd21;
        SUB_MODE_IN = 8'h5a;
        SETTLE_CYC  = 16'd1;
        DWELL_CYC   = 32'd3;
        START = 1'b1;
        step();
        START = 1'b0;
        step();
        step();
        #2 RSTX = 1'b0;
        #1;
        model_reset();
        check_outputs();
        #2 RSTX = 1'b1;
        prev_valid = 1'b0;
        repeat (3) step();
        run_sweep("after_rst", 8'd20, 8'd22, 16'd1, 32'd3, 1, -1, 0, 3, 1);

        for (int i = 0; i < 10; i++) begin
            rf = 8'($urandom_range(0, 250));
            rl = rf + 8'($urandom_range(0, 4));
            run_sweep("rnd", rf, rl, 16'($urandom_range(0, 4)), 32'($urandom_range(0, 6)),
                      1, -1, 0, int'(rl) - int'(rf) + 1, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
